// File: rtl/wd_pkg.sv
// Shared definitions for the link watchdog supervisor: FSM encoding and
// the width of the per-channel and ARM microsecond counters.
package wd_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } wd_state_e;

endpackage

// File: rtl/wd_channel.sv
// One heartbeat channel: 2-flop synchronizer, edge detect, saturating
// microsecond counter since the last edge, and a "seen since IDLE" flag.
module wd_channel
    import wd_pkg::*;
#(
    parameter int TIMEOUT_US = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    input  logic en_i,
    input  logic tick_i,
    input  logic cnt_clr_i,
    input  logic seen_clr_i,
    output logic expired_o,
    output logic seen_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_US);

    // [0],[1] form the synchronizer; [2] is the delayed copy for edge detect.
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             edge_w;

    assign edge_w = sync_q[1] ^ sync_q[2];

    always_comb begin
        cnt_d  = cnt_q;
        seen_d = seen_q;
        if (!en_i) begin
            cnt_d  = '0;
            seen_d = 1'b0;
        end else begin
            // An edge coinciding with a tick must still restart the count.
            if (edge_w || cnt_clr_i) begin
                cnt_d = '0;
            end else if (tick_i && (cnt_q < LIMIT)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (seen_clr_i) begin
                seen_d = 1'b0;
            end else if (edge_w) begin
                seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], sig_i};
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LIMIT);
    assign seen_o    = seen_q;

endmodule

// File: rtl/link_watchdog_supervisor.sv
// Power-stage supervisor: arms when every enabled heartbeat has toggled,
// runs with pwm_en high, and latches a fault on any heartbeat timeout.
module link_watchdog_supervisor
    import wd_pkg::*;
#(
    parameter int CLK_FREQ_MHZ   = 40,
    parameter int N_CH           = 4,
    parameter int TIMEOUT_US     = 1000,
    parameter int ARM_TIMEOUT_US = 10000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sig_in,
    input  logic [N_CH-1:0] ch_en,
    input  logic            run_req,
    input  logic            clr_req,
    output logic            pwm_en,
    output logic            fault,
    output logic [N_CH-1:0] fault_ch,
    output logic            arm_fail,
    output logic [1:0]      state,
    output logic            clr_ack
);

    localparam int               PRE_W   = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ_MHZ - 1);
    localparam logic [CNT_W-1:0] ARM_LIM = CNT_W'(ARM_TIMEOUT_US);

    logic [1:0]       rst_sync_q;
    logic [PRE_W-1:0] pre_q;
    logic             tick_w;
    logic [N_CH-1:0]  expired_w;
    logic [N_CH-1:0]  seen_w;
    logic             all_seen_w;
    logic             go_arm_w;

    wd_state_e        state_q;
    logic [CNT_W-1:0] arm_tmr_q;
    logic             pwm_en_q;
    logic             fault_q;
    logic [N_CH-1:0]  fault_ch_q;
    logic             arm_fail_q;
    logic             clr_ack_q;

    // Reset asserts asynchronously but the FSM only leaves IDLE once the
    // release has propagated through two clk flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign tick_w = (pre_q == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pre_q <= '0;
        else if (tick_w) pre_q <= '0;
        else             pre_q <= pre_q + PRE_W'(1);
    end

    assign go_arm_w   = (state_q == ST_IDLE) && run_req && rst_sync_q[1];
    assign all_seen_w = &(seen_w | ~ch_en);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        wd_channel #(
            .TIMEOUT_US(TIMEOUT_US)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .sig_i     (sig_in[g]),
            .en_i      (ch_en[g]),
            .tick_i    (tick_w),
            .cnt_clr_i (go_arm_w),
            .seen_clr_i(state_q == ST_IDLE),
            .expired_o (expired_w[g]),
            .seen_o    (seen_w[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            arm_tmr_q  <= '0;
            pwm_en_q   <= 1'b0;
            fault_q    <= 1'b0;
            fault_ch_q <= '0;
            arm_fail_q <= 1'b0;
            clr_ack_q  <= 1'b0;
        end else begin
            clr_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    pwm_en_q <= 1'b0;
                    if (go_arm_w) begin
                        state_q   <= ST_ARM;
                        arm_tmr_q <= '0;
                    end
                end
                ST_ARM: begin
                    if (tick_w && (arm_tmr_q < ARM_LIM)) arm_tmr_q <= arm_tmr_q + CNT_W'(1);
                    if (!run_req) begin
                        state_q <= ST_IDLE;
                    end else if (all_seen_w) begin
                        state_q  <= ST_RUN;
                        pwm_en_q <= 1'b1;
                    end else if (arm_tmr_q == ARM_LIM) begin
                        state_q    <= ST_FAULT;
                        fault_q    <= 1'b1;
                        arm_fail_q <= 1'b1;
                        fault_ch_q <= ch_en & ~seen_w;
                    end
                end
                ST_RUN: begin
                    // Expiry outranks a simultaneous run_req drop.
                    if (|expired_w) begin
                        state_q    <= ST_FAULT;
                        pwm_en_q   <= 1'b0;
                        fault_q    <= 1'b1;
                        fault_ch_q <= expired_w;
                    end else if (!run_req) begin
                        state_q  <= ST_IDLE;
                        pwm_en_q <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    pwm_en_q <= 1'b0;
                    if (clr_req && !run_req) begin
                        state_q    <= ST_IDLE;
                        fault_q    <= 1'b0;
                        fault_ch_q <= '0;
                        arm_fail_q <= 1'b0;
                        clr_ack_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pwm_en   = pwm_en_q;
    assign fault    = fault_q;
    assign fault_ch = fault_ch_q;
    assign arm_fail = arm_fail_q;
    assign state    = state_q;
    assign clr_ack  = clr_ack_q;

endmodule

// File: tb/tb_link_watchdog_supervisor.sv
// Directed bench for link_watchdog_supervisor at 4 MHz / 5 us / 8 us;
// a negedge monitor pops expected snapshots, fault events and clear acks.
module tb_link_watchdog_supervisor;

    logic       clk;
    logic       rst_n;
    logic [3:0] sig_in;
    logic [3:0] ch_en;
    logic       run_req;
    logic       clr_req;
    logic       pwm_en;
    logic       fault;
    logic [3:0] fault_ch;
    logic       arm_fail;
    logic [1:0] state;
    logic       clr_ack;

    logic [3:0] tog_en;
    int         cyc = 0;
    int         last_tog[4];
    int         fault_cyc = 0;
    int         arm_cyc;
    int         n_checks = 0;
    int         n_pass = 0;

    // snapshot vector: {state, pwm_en, fault, arm_fail, clr_ack, fault_ch}
    logic [9:0] exp_q[$];
    string      name_q[$];
    logic [5:0] fexp_q[$];  // {pwm_en, arm_fail, fault_ch} at fault rise
    logic [5:0] aexp_q[$];  // {state, fault_ch} while clr_ack is high

    link_watchdog_supervisor #(
        .CLK_FREQ_MHZ  (4),
        .N_CH          (4),
        .TIMEOUT_US    (5),
        .ARM_TIMEOUT_US(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .ch_en   (ch_en),
        .run_req (run_req),
        .clr_req (clr_req),
        .pwm_en  (pwm_en),
        .fault   (fault),
        .fault_ch(fault_ch),
        .arm_fail(arm_fail),
        .state   (state),
        .clr_ack (clr_ack)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

    // Heartbeat source: every enabled bit toggles once per 8 clk (2 us).
    initial begin
        sig_in = '0;
        for (int i = 0; i < 4; i++) last_tog[i] = 0;
        forever begin
            @(posedge clk);
            #2;
            if (cyc % 8 == 0) begin
                sig_in = sig_in ^ tog_en;
                for (int i = 0; i < 4; i++) if (tog_en[i]) last_tog[i] = cyc;
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: actual=%0d expected in [%0d,%0d]", nm, act, lo, hi);
    endtask

    function automatic logic [9:0] mk(input logic [1:0] st, input logic pwm, input logic flt,
                                      input logic af, input logic ack, input logic [3:0] fc);
        return {st, pwm, flt, af, ack, fc};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic       fault_prev;
        logic [9:0] obs;
        logic [9:0] e;
        logic [5:0] fe;
        string      nm;
        fault_prev = 1'b0;
        forever begin
            @(negedge clk);
            obs = {state, pwm_en, fault, arm_fail, clr_ack, fault_ch};
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, 32'(obs), 32'(e));
            end
            if (fault && !fault_prev) begin
                fault_cyc = cyc;
                if (fexp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_fault: actual fault_ch=0x%0h expected no fault", fault_ch);
                end else begin
                    fe = fexp_q.pop_front();
                    chk("fault_event", 32'({pwm_en, arm_fail, fault_ch}), 32'(fe));
                end
            end
            fault_prev = fault;
            if (clr_ack) begin
                if (aexp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_clr_ack: actual clr_ack=1 expected 0");
                end else begin
                    fe = aexp_q.pop_front();
                    chk("clr_ack_event", 32'({state, fault_ch}), 32'(fe));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap(input string nm, input logic [9:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string nm);
        int k;
        k = 0;
        while (state !== st && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (state !== st) begin
            n_checks++;
            $display("FAIL %s: actual state=%0d expected %0d within %0d cycles", nm, state, st, budget);
        end
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        step(1);
        clr_req = 1'b0;
    endtask

    task automatic clear_fault();
        run_req = 1'b0;
        step(1);
        aexp_q.push_back(6'b00_0000);
        pulse_clr();
        step(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        run_req = 1'b0;
        clr_req = 1'b0;
        ch_en   = 4'hF;
        tog_en  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        snap("reset_state", mk(2'd0, 0, 0, 0, 0, 4'h0));
        rst_n = 1'b1;
        step(4);
        snap("idle_after_reset", mk(2'd0, 0, 0, 0, 0, 4'h0));

        // All channels alive: ARM then RUN, stable for 100 us.
        tog_en  = 4'hF;
        run_req = 1'b1;
        step(1);
        snap("enter_arm", mk(2'd1, 0, 0, 0, 0, 4'h0));
        wait_state(2'd2, 40, "arm_to_run");
        snap("run_pwm_on", mk(2'd2, 1, 0, 0, 0, 4'h0));
        pulse_clr();
        step(2);
        snap("clr_in_run_no_effect", mk(2'd2, 1, 0, 0, 0, 4'h0));
        step(400);
        snap("run_after_100us", mk(2'd2, 1, 0, 0, 0, 4'h0));

        // Channel 2 goes silent.
        fexp_q.push_back(6'b00_0100);
        tog_en = 4'b1011;
        wait_state(2'd3, 60, "ch2_fault_wait");
        snap("ch2_fault_state", mk(2'd3, 0, 1, 0, 0, 4'b0100));
        chk_range("ch2_fault_latency", fault_cyc - last_tog[2], 16, 24);

        // Clear is refused while run_req is still high, accepted once low.
        pulse_clr();
        step(3);
        snap("clr_ignored_run_req", mk(2'd3, 0, 1, 0, 0, 4'b0100));
        clear_fault();
        snap("cleared_to_idle", mk(2'd0, 0, 0, 0, 0, 4'h0));

        // Channels 0 and 3 go silent together.
        tog_en  = 4'hF;
        run_req = 1'b1;
        wait_state(2'd2, 60, "rerun_wait");
        step(20);
        fexp_q.push_back(6'b00_1001);
        tog_en = 4'b0110;
        wait_state(2'd3, 60, "ch03_fault_wait");
        snap("ch03_fault_state", mk(2'd3, 0, 1, 0, 0, 4'b1001));
        clear_fault();
        snap("cleared_after_ch03", mk(2'd0, 0, 0, 0, 0, 4'h0));

        // ARM with channel 1 silent: ARM timeout.
        tog_en = 4'b1101;
        fexp_q.push_back(6'b01_0010);
        run_req = 1'b1;
        arm_cyc = cyc;
        wait_state(2'd3, 60, "arm_fail_wait");
        snap("arm_fail_state", mk(2'd3, 0, 1, 1, 0, 4'b0010));
        chk_range("arm_timeout_latency", fault_cyc - arm_cyc, 29, 36);
        clear_fault();
        snap("cleared_after_arm_fail", mk(2'd0, 0, 0, 0, 0, 4'h0));

        // No channels enabled: ARM passes straight to RUN.
        ch_en   = 4'h0;
        tog_en  = 4'h0;
        run_req = 1'b1;
        step(1);
        snap("empty_mask_arm", mk(2'd1, 0, 0, 0, 0, 4'h0));
        step(1);
        snap("empty_mask_run", mk(2'd2, 1, 0, 0, 0, 4'h0));
        run_req = 1'b0;
        step(1);
        snap("run_req_drop_idle", mk(2'd0, 0, 0, 0, 0, 4'h0));

        // Asynchronous reset in RUN.
        ch_en   = 4'hF;
        tog_en  = 4'hF;
        run_req = 1'b1;
        wait_state(2'd2, 60, "run_before_reset");
        step(5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        snap("async_reset_in_run", mk(2'd0, 0, 0, 0, 0, 4'h0));
        run_req = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        snap("after_reset_release", mk(2'd0, 0, 0, 0, 0, 4'h0));

        step(2);
        chk("fault_queue_drained", 32'(fexp_q.size()), 32'd0);
        chk("ack_queue_drained", 32'(aexp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
